// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the dot_product / scale datapath:
// word and accumulator widths, the dot-product FSM states and the saturator.
package fixed_pkg;

  localparam int Q_BITS_DEFAULT = 10;
  localparam int WORD_W         = 32;
  localparam int PROD_W         = 2 * WORD_W;
  localparam int ACC_W          = 66;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WR   = 2'd2
  } state_e;

  // A value fits in a signed word only when every bit from the word's sign bit
  // upward is identical.
  function automatic logic sat_needed(input logic signed [ACC_W-1:0] v);
    return !((&v[ACC_W-1:WORD_W-1]) || !(|v[ACC_W-1:WORD_W-1]));
  endfunction

  function automatic logic [WORD_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
    if (!sat_needed(v)) begin
      return v[WORD_W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(WORD_W-1){1'b0}}};
    end else begin
      return {1'b0, {(WORD_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/dot_product_core.sv
// Sequenced 3-term fixed-point dot product: pop one operand pair, run one
// shared multiplier over three cycles, then write the saturated result.
module dot_product_core
  import fixed_pkg::*;
#(
  parameter int Q_BITS = Q_BITS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0][WORD_W-1:0] x,
  input  logic [2:0][WORD_W-1:0] y,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [WORD_W-1:0]      out_din,
  output logic                   sat_flag
);

  state_e                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0][WORD_W-1:0]   xr_q, xr_d;
  logic [2:0][WORD_W-1:0]   yr_q, yr_d;
  logic                     sat_flag_q, sat_flag_d;

  logic signed [WORD_W-1:0] x_sel, y_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic                     result_sat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!in_empty)       state_d = S_MAC;
      S_MAC:   if (idx_q == 2'd2)   state_d = S_WR;
      S_WR:    if (!out_full)       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // The pop is gated by reset so nothing is consumed while the block is held.
  always_comb begin
    in_rd_en  = reset && (state_q == S_IDLE) && !in_empty;
    out_wr_en = (state_q == S_WR) && !out_full;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    case (idx_q)
      2'd0: begin x_sel = xr_q[0]; y_sel = yr_q[0]; end
      2'd1: begin x_sel = xr_q[1]; y_sel = yr_q[1]; end
      2'd2: begin x_sel = xr_q[2]; y_sel = yr_q[2]; end
      default: begin x_sel = '0; y_sel = '0; end
    endcase
    prod = PROD_W'(x_sel) * PROD_W'(y_sel);
  end

  // The full-precision sum is shifted once, so floor applies to the total.
  always_comb begin
    shifted    = acc_q >>> Q_BITS;
    out_din    = sat32(shifted);
    result_sat = sat_needed(shifted);
  end

  always_comb begin
    xr_d       = xr_q;
    yr_d       = yr_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    sat_flag_d = sat_flag_q | (out_wr_en & result_sat);
    if (in_rd_en) begin
      xr_d  = x;
      yr_d  = y;
      acc_d = '0;
      idx_d = 2'd0;
    end else if (state_q == S_MAC) begin
      acc_d = acc_q + ACC_W'(prod);
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xr_q       <= '0;
      yr_q       <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      xr_q       <= xr_d;
      yr_q       <= yr_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;

endmodule

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags;
// dout always shows the entry at the read pointer.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_wr, do_rd;

  // Requests against a full or empty FIFO are dropped here, so callers may
  // hold wr_en/rd_en without qualifying them.
  always_comb begin
    do_wr    = wr_en && !full_q;
    do_rd    = rd_en && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/dot_product.sv
// Fixed-point 3-vector dot product: compute core feeding a scalar output FIFO,
// whose dout/empty/rd_en form the downstream interface to scale.
module dot_product
  import fixed_pkg::*;
#(
  parameter int Q_BITS           = Q_BITS_DEFAULT,
  parameter int FIFO_BUFFER_SIZE = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0][WORD_W-1:0] x,
  input  logic [2:0][WORD_W-1:0] y,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  output logic [WORD_W-1:0]      out,
  output logic                   out_empty,
  input  logic                   out_rd_en,
  output logic                   sat_flag
);

  logic              out_full;
  logic              out_wr_en;
  logic [WORD_W-1:0] out_din;

  dot_product_core #(
    .Q_BITS(Q_BITS)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din),
    .sat_flag  (sat_flag)
  );

  fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_BUFFER_SIZE)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (out_wr_en),
    .din   (out_din),
    .full  (out_full),
    .rd_en (out_rd_en),
    .dout  (out),
    .empty (out_empty)
  );

endmodule

// File: tb/tb_dot_product.sv
// Self-checking bench for dot_product (Q_BITS=10, 4-deep output FIFO) against
// an arbitrary-precision arithmetic model of floor(x.y / 2^10) with saturation.
module tb_dot_product;

  typedef logic [2:0][31:0] vec3_t;
  typedef struct packed {
    vec3_t xv;
    vec3_t yv;
  } pair_t;

  logic        clock = 1'b0;
  logic        reset;
  vec3_t       x, y;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out;
  logic        out_empty;
  logic        out_rd_en;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  pair_t       src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          exp_sat;
  int          pop_count;
  int          rd_violations;
  bit          last_pop;
  bit          last_empty;

  dot_product #(
    .Q_BITS(10),
    .FIFO_BUFFER_SIZE(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (out),
    .out_empty (out_empty),
    .out_rd_en (out_rd_en),
    .sat_flag  (sat_flag)
  );

  always #5 clock = ~clock;

  // {saturated, value}: exact sum, floor division by 2^10, then clamp.
  function automatic logic [32:0] golden(input vec3_t xv, input vec3_t yv);
    logic signed [127:0] s, q;
    s = 128'sd0;
    for (int i = 0; i < 3; i++) begin
      s = s + 128'(signed'(xv[i])) * 128'(signed'(yv[i]));
    end
    q = s / 128'sd1024;
    if (s < 128'sd0 && (s % 128'sd1024) != 128'sd0) q = q - 128'sd1;
    if (q > 128'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (q < -128'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, q[31:0]};
  endfunction

  function automatic vec3_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [31:0] rand_word();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = int'($urandom_range(0, 2097152)) - 1048576;
    return 32'(v);
  endfunction

  task automatic push_pair(input vec3_t a, input vec3_t b);
    pair_t p;
    p.xv = a;
    p.yv = b;
    src_q.push_back(p);
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    pop_count = 0;
  endtask

  // One clock of upstream/downstream emulation; the pop/read decided here
  // takes effect at the following posedge.
  task automatic step(input bit allow_in, input bit want_rd);
    logic [32:0] g;
    @(negedge clock);
    if (allow_in && src_q.size() > 0) begin
      in_empty = 1'b0;
      x = src_q[0].xv;
      y = src_q[0].yv;
    end else begin
      in_empty = 1'b1;
      x = {$urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom};
    end
    last_empty = out_empty;
    out_rd_en  = want_rd;
    if (want_rd && !out_empty) got_q.push_back(out);
    #1;
    last_pop = in_rd_en;
    if (in_rd_en) begin
      if (in_empty) begin
        rd_violations++;
      end else begin
        g = golden(src_q[0].xv, src_q[0].yv);
        exp_q.push_back(g[31:0]);
        exp_sat = exp_sat | g[32];
        void'(src_q.pop_front());
        pop_count++;
      end
    end
  endtask

  task automatic collect(input int n, input bit allow_in, input int budget, output bit timed_out);
    int c;
    c = 0;
    timed_out = 1'b0;
    while (got_q.size() < n) begin
      if (c >= budget) begin
        timed_out = 1'b1;
        break;
      end
      step(allow_in, 1'b1);
      c++;
    end
    @(posedge clock);
    #1;
    out_rd_en = 1'b0;
    in_empty  = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    exp_sat = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    in_empty = 1'b0;
    #1;
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_rd_en: got %b expected 0", in_rd_en); end
    checks++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_out_empty: got %b expected 1", out_empty); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_flag: got %b expected 0", sat_flag); end
    in_empty = 1'b1;
    release_reset();
  endtask

  task automatic test_basic();
    int first_ne, mid_pops, c;
    bit pop5, to;
    clear_model();
    push_pair(mk(32'd1024, 32'd2048, 32'd3072), mk(32'd1024, 32'd1024, 32'd1024));
    push_pair(mk(rand_word(), 32'd5, 32'd7), mk(32'd3, rand_word(), 32'd11));
    c = 0;
    do begin step(1'b1, 1'b0); c++; end while (!last_pop && c < 10);
    checks++; if (!last_pop) begin errors++; $display("[TB] FAIL basic_pop: no pop within 10 cycles"); end
    first_ne = 0; mid_pops = 0; pop5 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      if (!last_empty && first_ne == 0) first_ne = i;
      if (i <= 4 && last_pop) mid_pops++;
      if (i == 5) pop5 = last_pop;
    end
    checks++; if (first_ne != 5) begin errors++; $display("[TB] FAIL basic_latency: out_empty fell %0d cycles after pop, expected 5", first_ne); end
    checks++; if (mid_pops != 0) begin errors++; $display("[TB] FAIL basic_single_pop: got %0d extra pops, expected 0", mid_pops); end
    checks++; if (pop5 !== 1'b1) begin errors++; $display("[TB] FAIL basic_throughput: next pop at +5 was %b expected 1", pop5); end
    collect(2, 1'b0, 50, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got %0d results expected 2", got_q.size()); end
    if (!to) begin
      checks++; if (got_q[0] !== 32'd6144) begin errors++; $display("[TB] FAIL basic_value: got %0d expected 6144", got_q[0]); end
      checks++; if (got_q[1] !== exp_q[1]) begin errors++; $display("[TB] FAIL basic_value2: got %h expected %h", got_q[1], exp_q[1]); end
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_sat_flag: got %b expected 0", sat_flag); end
  endtask

  task automatic test_sign();
    bit to;
    logic [31:0] want [3];
    clear_model();
    push_pair(mk(-32'sd1024, 32'd0, 32'd0), mk(32'd512, 32'd0, 32'd0));
    push_pair(mk(32'd1, 32'd0, 32'd0), mk(-32'sd1, 32'd0, 32'd0));
    push_pair(mk(32'd1, 32'd1, 32'd0), mk(32'd512, 32'd512, 32'd0));
    want[0] = 32'hFFFF_FE00;
    want[1] = 32'hFFFF_FFFF;
    want[2] = 32'h0000_0001;
    collect(3, 1'b1, 100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL sign_timeout: got %0d results expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== want[i]) begin errors++; $display("[TB] FAIL sign_floor_%0d: got %h expected %h", i, got_q[i], want[i]); end
      end
    end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL sign_sat_flag: got %b expected 0", sat_flag); end
  endtask

  task automatic test_saturation();
    bit to;
    clear_model();
    push_pair(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
    collect(1, 1'b1, 50, to);
    checks++; if (to || got_q[0] !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL sat_pos: got %h expected 7fffffff", to ? 32'hx : got_q[0]); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag_set: got %b expected 1", sat_flag); end
    clear_model();
    push_pair(mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000), mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
    collect(1, 1'b1, 50, to);
    checks++; if (to || got_q[0] !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sat_neg: got %h expected 80000000", to ? 32'hx : got_q[0]); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag_sticky: got %b expected 1", sat_flag); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_model();
    rd_violations = 0;
    for (int i = 0; i < 6; i++) push_pair({rand_word(), rand_word(), rand_word()}, {rand_word(), rand_word(), rand_word()});
    repeat (40) step(1'b1, 1'b0);
    checks++; if (pop_count != 5) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 5", pop_count); end
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_rd: got %b expected 0", in_rd_en); end
    checks++; if (out_empty !== 1'b0) begin errors++; $display("[TB] FAIL bp_stored: out_empty %b expected 0", out_empty); end
    collect(6, 1'b1, 200, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL bp_timeout: got %0d results expected 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size() && i < exp_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    repeat (8) step(1'b0, 1'b0);
    checks++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_extra: out_empty %b expected 1", out_empty); end
    checks++; if (rd_violations != 0) begin errors++; $display("[TB] FAIL bp_rd_when_empty: got %0d expected 0", rd_violations); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int c;
    logic [32:0] g;
    vec3_t cx, cy;
    clear_model();
    push_pair(mk(32'd100, 32'd200, 32'd300), mk(32'd4096, 32'd4096, 32'd4096));
    push_pair(mk(32'd7, 32'd8, 32'd9), mk(32'd1024, 32'd1024, 32'd1024));
    c = 0;
    while (pop_count < 2 && c < 40) begin step(1'b1, 1'b0); c++; end
    step(1'b0, 1'b0);
    checks++; if (out_empty !== 1'b0 || pop_count != 2) begin errors++; $display("[TB] FAIL rst_mid_setup: out_empty %b pops %0d expected 0 and 2", out_empty, pop_count); end
    reset = 1'b0;
    #1;
    checks++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_empty: got %b expected 1", out_empty); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sat: got %b expected 0", sat_flag); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_out: got %h expected 00000000", out); end
    repeat (2) @(negedge clock);
    release_reset();
    cx = mk(32'd3072, -32'sd5000, 32'd1);
    cy = mk(32'd2048, 32'd1024, -32'sd1);
    g = golden(cx, cy);
    push_pair(cx, cy);
    collect(1, 1'b1, 50, to);
    checks++; if (to || got_q[0] !== g[31:0]) begin errors++; $display("[TB] FAIL rst_mid_after: got %h expected %h", to ? 32'hx : got_q[0], g[31:0]); end
    repeat (8) step(1'b0, 1'b0);
    checks++; if (out_empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_no_ghost: out_empty %b expected 1", out_empty); end
  endtask

  task automatic test_random();
    int done, cyc;
    logic [31:0] e;
    clear_model();
    rd_violations = 0;
    for (int i = 0; i < 1000; i++) push_pair({rand_word(), rand_word(), rand_word()}, {rand_word(), rand_word(), rand_word()});
    done = 0;
    cyc = 0;
    while (done < 1000 && cyc < 30000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
      cyc++;
      while (got_q.size() > 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL random_extra: got %h expected nothing", got_q[0]);
        end else begin
          e = exp_q.pop_front();
          if (got_q[0] !== e) begin errors++; $display("[TB] FAIL random_%0d: got %h expected %h", done, got_q[0], e); end
        end
        void'(got_q.pop_front());
        done++;
      end
    end
    @(posedge clock);
    #1;
    out_rd_en = 1'b0;
    in_empty  = 1'b1;
    checks++; if (done != 1000) begin errors++; $display("[TB] FAIL random_count: got %0d results expected 1000", done); end
    checks++; if (rd_violations != 0) begin errors++; $display("[TB] FAIL random_rd_when_empty: got %0d expected 0", rd_violations); end
    checks++; if (sat_flag !== exp_sat) begin errors++; $display("[TB] FAIL random_sat_flag: got %b expected %b", sat_flag, exp_sat); end
  endtask

  initial begin
    reset         = 1'b1;
    in_empty      = 1'b1;
    out_rd_en     = 1'b0;
    x             = '0;
    y             = '0;
    exp_sat       = 1'b0;
    pop_count     = 0;
    rd_violations = 0;
    last_pop      = 1'b0;
    last_empty    = 1'b1;
    #2 reset = 1'b0;
    test_reset();
    test_basic();
    test_sign();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
